// File: rtl/omr_machine.sv
// rtl/omr_machine.sv - OMR sheet scorer with optional negative marking
//
// Purpose:
//   Grades one answer sheet per cycle. Each question's student nibble is
//   compared to the key nibble: all-zero is blank, a non-zero exact match
//   is right, and anything else is wrong. The graded result is registered
//   one cycle after the sheet is sampled.
//
// Configuration macro: OMR_NEG_MARKING_EN
//   defined   : score = max(R - W, 0), score_neg = W
//   undefined : score = R, score_neg = 0
//
// Ports:
//   clk             in   single clock, rising-edge
//   reset           in   asynchronous active-low reset
//   in_valid        in   sheet present on the answer buses
//   correct_answers in   NUM_Q*OPT_W answer key, question 1 in the MSBs
//   student_answers in   NUM_Q*OPT_W student marks, same packing
//   score           out  4-bit net score (registered)
//   score_neg       out  4-bit wrong-answer count (registered)
//   out_valid       out  score/score_neg hold a new result (registered)

module omr_machine #(
  parameter int NUM_Q = 10,
  parameter int OPT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [NUM_Q*OPT_W-1:0] correct_answers,
  input  logic [NUM_Q*OPT_W-1:0] student_answers,
  output logic [3:0]             score,
  output logic [3:0]             score_neg,
  output logic                   out_valid
);

  logic [3:0] right_cnt;
`ifdef OMR_NEG_MARKING_EN
  logic [3:0] wrong_cnt;
`endif
  logic [3:0] score_d;
  logic [3:0] score_neg_d;
  logic [3:0] score_q;
  logic [3:0] score_neg_q;
  logic       out_valid_q;

  always_comb begin
    right_cnt = 4'd0;
`ifdef OMR_NEG_MARKING_EN
    wrong_cnt = 4'd0;
`endif
    for (int q = 0; q < NUM_Q; q++) begin
      // Blank questions fall through both branches and count nowhere.
      if (student_answers[q*OPT_W +: OPT_W] != '0) begin
        if (student_answers[q*OPT_W +: OPT_W] == correct_answers[q*OPT_W +: OPT_W]) begin
          right_cnt = right_cnt + 4'd1;
        end
`ifdef OMR_NEG_MARKING_EN
        else begin
          wrong_cnt = wrong_cnt + 4'd1;
        end
`endif
      end
    end
  end

  always_comb begin
`ifdef OMR_NEG_MARKING_EN
    // Clamp at zero rather than letting the subtraction wrap.
    score_d     = (right_cnt > wrong_cnt) ? (right_cnt - wrong_cnt) : 4'd0;
    score_neg_d = wrong_cnt;
`else
    score_d     = right_cnt;
    score_neg_d = 4'd0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q     <= 4'd0;
      score_neg_q <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      // Results are held across idle cycles; only a new sheet updates them.
      if (in_valid) begin
        score_q     <= score_d;
        score_neg_q <= score_neg_d;
      end
    end
  end

  assign score     = score_q;
  assign score_neg = score_neg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_omr_machine.sv
// tb/tb_omr_machine.sv - scoreboard testbench for omr_machine

module tb_omr_machine;

  localparam int NUM_Q = 10;
  localparam int OPT_W = 4;
  localparam logic [39:0] KEY = 40'h1224121888;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic [NUM_Q*OPT_W-1:0] correct_answers;
  logic [NUM_Q*OPT_W-1:0] student_answers;
  logic [3:0]             score;
  logic [3:0]             score_neg;
  logic                   out_valid;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [3:0] last_s;
  logic [3:0] last_n;

  omr_machine #(.NUM_Q(NUM_Q), .OPT_W(OPT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .correct_answers (correct_answers),
    .student_answers (student_answers),
    .score           (score),
    .score_neg       (score_neg),
    .out_valid       (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got score=%0d neg=%0d expected none", score, score_neg);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("score", score, e[7:4]);
        chk("score_neg", score_neg, e[3:0]);
      end
    end
  end

  // Present one sheet at a falling edge; expected values for both builds.
  task automatic send(input logic [39:0] key, input logic [39:0] stu,
                      input logic [3:0] s_en, input logic [3:0] n_en,
                      input logic [3:0] s_dis);
    @(negedge clk);
    in_valid        = 1'b1;
    correct_answers = key;
    student_answers = stu;
`ifdef OMR_NEG_MARKING_EN
    exp_q.push_back({s_en, n_en});
    last_s = s_en;
    last_n = n_en;
`else
    exp_q.push_back({s_dis, 4'd0});
    last_s = s_dis;
    last_n = 4'd0;
`endif
  endtask

  task automatic idle_check();
    @(negedge clk);
    in_valid        = 1'b0;
    student_answers = '1;
    @(negedge clk);
    chk("idle_out_valid", {3'b0, out_valid}, 4'd0);
    chk("hold_score", score, last_s);
    chk("hold_score_neg", score_neg, last_n);
  endtask

  initial begin
    reset           = 1'b0;
    in_valid        = 1'b0;
    correct_answers = '0;
    student_answers = '0;
    last_s          = 4'd0;
    last_n          = 4'd0;
    #12;
    chk("rst_score", score, 4'd0);
    chk("rst_score_neg", score_neg, 4'd0);
    chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back sheets with in_valid held high.
    send(KEY, KEY,           4'd10, 4'd0, 4'd10);
    send(KEY, 40'h8224244888, 4'd2,  4'd4, 4'd6);
    send(KEY, 40'h1224121218, 4'd6,  4'd2, 4'd8);
    send(KEY, 40'h1228121888, 4'd8,  4'd1, 4'd9);
    send(KEY, 40'h8424424212, 4'd0,  4'd7, 4'd3);
    send(KEY, 40'h0000000000, 4'd0,  4'd0, 4'd0);
    send(KEY, 40'h3224121888, 4'd8,  4'd1, 4'd9);
    send(KEY, 40'h1224144444, 4'd0,  4'd5, 4'd5);
    send(40'h3333333333, 40'h3333333333, 4'd10, 4'd0, 4'd10);
    send(40'h3333333333, 40'h1111111111, 4'd0,  4'd10, 4'd0);
    idle_check();

    send(KEY, 40'h1224121218, 4'd6, 4'd2, 4'd8);
    idle_check();

    // Reset between two back-to-back sheets: the second must never appear.
    send(KEY, 40'h8224244888, 4'd2, 4'd4, 4'd6);
    @(negedge clk);
    student_answers = KEY;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_score", score, 4'd0);
    chk("async_rst_score_neg", score_neg, 4'd0);
    chk("async_rst_out_valid", {3'b0, out_valid}, 4'd0);
    @(negedge clk);
    chk("rst_hold_out_valid", {3'b0, out_valid}, 4'd0);
    reset = 1'b1;
    last_s = 4'd0;
    last_n = 4'd0;
    // Sheet presented for the first edge after reset release.
    in_valid        = 1'b1;
    correct_answers = KEY;
    student_answers = 40'h1228121888;
`ifdef OMR_NEG_MARKING_EN
    exp_q.push_back({4'd8, 4'd1});
    last_s = 4'd8;
    last_n = 4'd1;
`else
    exp_q.push_back({4'd9, 4'd0});
    last_s = 4'd9;
`endif
    idle_check();

    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_results: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
